debounced_logic_unit: RTL and testbench



---
 rtl/debounced_logic_unit.sv | 135 +++++++++++++
 tb/tb_debounced_logic_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/debounced_logic_unit.sv
// debounced_logic_unit: per-channel synchroniser and debouncer feeding a
// mode-selectable reduction (AND/OR/XOR/majority) with a change pulse.
// Optional build macro DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN adds per-channel
// rise/fall pulse outputs aligned with the debounced-vector update.
module debounced_logic_unit #(
    parameter int unsigned N             = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] db,
    output logic         e,
    output logic         f
`ifdef DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN
    ,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
`endif
);

    localparam int unsigned      PC_W     = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PC_W-1:0]  MAJ_HALF = PC_W'(N / 2);

    typedef enum logic [1:0] {
        MODE_AND = 2'b00,
        MODE_OR  = 2'b01,
        MODE_XOR = 2'b10,
        MODE_MAJ = 2'b11
    } mode_e;

    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [CNT_W-1:0] cnt     [N];
    logic [CNT_W-1:0] cnt_nxt [N];
    logic [N-1:0]     db_nxt;
    logic [PC_W-1:0]  pop_c;
    logic             red_c;

    // Two-flop synchroniser; keeps sampling even while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Per-channel debounce next state: any agreement restarts the count,
    // the last disagreeing cycle commits s2 and clears the counter.
    always_comb begin
        db_nxt = db;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state register; en low freezes counters and db.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            db <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            db <= db_nxt;
        end
    end

    // Population count of the debounced vector for majority mode.
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_c = pop_c + PC_W'(db[i]);
        end
    end

    // Mode-selected reduction of the current debounced vector.
    always_comb begin
        red_c = 1'b0;
        case (mode_e'(mode))
            MODE_AND: red_c = &db;
            MODE_OR:  red_c = |db;
            MODE_XOR: red_c = ^db;
            MODE_MAJ: red_c = (pop_c > MAJ_HALF);
            default:  red_c = 1'b0;
        endcase
    end

    // Registered reduction and its one-cycle change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            e <= 1'b0;
            f <= 1'b0;
        end else if (en) begin
            e <= red_c;
            f <= (red_c != e);
        end else begin
            f <= 1'b0;
        end
    end

`ifdef DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN
    // Edge pulses registered on the same edge db itself changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else if (en) begin
            rise <= db_nxt & ~db;
            fall <= ~db_nxt & db;
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_debounced_logic_unit.sv
// Directed bench for debounced_logic_unit (N=4, STABLE_CYCLES=4).
// Expected db/e/f (and rise/fall when the edge-output macro is defined)
// are queued as each edge is driven and compared after that edge.
module tb_debounced_logic_unit;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned SC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] db;
    logic         e;
    logic         f;
`ifdef DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN
    logic [N-1:0] rise;
    logic [N-1:0] fall;
`endif

    always #5 clk = ~clk;

    debounced_logic_unit #(
        .N             (N),
        .CNT_W         (CW),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .mode (mode),
        .db   (db),
        .e    (e),
        .f    (f)
`ifdef DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN
        ,
        .rise (rise),
        .fall (fall)
`endif
    );

    typedef struct packed {
        logic [N-1:0] db;
        logic         e;
        logic         f;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    exp_t         sb_q[$];
    string        tag_q[$];
    int           checks  = 0;
    int           errors  = 0;
    logic [N-1:0] prev_db = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation for the coming edge, clock it, then compare.
    task automatic step(input string tag, input logic [N-1:0] x_db,
                        input logic x_e, input logic x_f);
        exp_t  x;
        exp_t  got;
        string t;
        x.db = x_db;
        x.e  = x_e;
        x.f  = x_f;
        if (rst || !en) begin
            x.rise = '0;
            x.fall = '0;
        end else begin
            x.rise = x_db & ~prev_db;
            x.fall = ~x_db & prev_db;
        end
        prev_db = x_db;
        sb_q.push_back(x);
        tag_q.push_back(tag);
        tick();
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert ({db, e, f} === {got.db, got.e, got.f}) else begin
            errors++;
            $error("FAIL %s: observed db=%b e=%b f=%b, expected db=%b e=%b f=%b",
                   t, db, e, f, got.db, got.e, got.f);
        end
`ifdef DEBOUNCED_LOGIC_UNIT_EDGE_OUT_EN
        checks++;
        assert ({rise, fall} === {got.rise, got.fall}) else begin
            errors++;
            $error("FAIL %s_edge: observed rise=%b fall=%b, expected rise=%b fall=%b",
                   t, rise, fall, got.rise, got.fall);
        end
`endif
    endtask

    task automatic run(input string tag, input int n, input logic [N-1:0] x_db,
                       input logic x_e, input logic x_f);
        for (int k = 0; k < n; k++) begin
            step(tag, x_db, x_e, x_f);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'b00;
        din  = 4'hF;

        // Reset holds everything at zero despite din=F.
        run("reset", 3, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        run("rel_wait", 5, 4'h0, 1'b0, 1'b0);
        step("rel_db", 4'hF, 1'b0, 1'b0);
        step("rel_e", 4'hF, 1'b1, 1'b1);
        step("rel_hold", 4'hF, 1'b1, 1'b0);

        // Return to zero.
        din = 4'h0;
        run("clr_wait", 5, 4'hF, 1'b1, 1'b0);
        step("clr_db", 4'h0, 1'b1, 1'b0);
        step("clr_e", 4'h0, 1'b0, 1'b1);
        step("clr_hold", 4'h0, 1'b0, 1'b0);

        // Three-cycle glitch never reaches db.
        din = 4'b0001;
        run("glitch3", 3, 4'h0, 1'b0, 1'b0);
        din = 4'b0000;
        run("glitch3_after", 8, 4'h0, 1'b0, 1'b0);

        // Four-cycle pulse is accepted, then released again.
        din = 4'b0001;
        run("pulse4", 4, 4'h0, 1'b0, 1'b0);
        din = 4'b0000;
        step("pulse4_w", 4'h0, 1'b0, 1'b0);
        step("pulse4_db", 4'b0001, 1'b0, 1'b0);
        run("pulse4_hold", 3, 4'b0001, 1'b0, 1'b0);
        step("pulse4_back", 4'h0, 1'b0, 1'b0);

        // Mode sweep on db=0111.
        din = 4'b0111;
        run("sweep_wait", 5, 4'h0, 1'b0, 1'b0);
        step("sweep_db", 4'b0111, 1'b0, 1'b0);
        step("m_and", 4'b0111, 1'b0, 1'b0);
        mode = 2'b01;
        step("m_or", 4'b0111, 1'b1, 1'b1);
        step("m_or_hold", 4'b0111, 1'b1, 1'b0);
        mode = 2'b10;
        step("m_xor", 4'b0111, 1'b1, 1'b0);
        mode = 2'b11;
        step("m_maj3", 4'b0111, 1'b1, 1'b0);
        din = 4'b0011;
        run("maj_wait", 5, 4'b0111, 1'b1, 1'b0);
        step("maj_db", 4'b0011, 1'b1, 1'b0);
        step("maj2_e", 4'b0011, 1'b0, 1'b1);
        step("maj2_hold", 4'b0011, 1'b0, 1'b0);

        // Enable freeze at cnt=2; a mode change while frozen must not pulse f.
        mode = 2'b01;
        step("or_e", 4'b0011, 1'b1, 1'b1);
        step("or_hold", 4'b0011, 1'b1, 1'b0);
        din = 4'b0000;
        run("frz_cnt", 4, 4'b0011, 1'b1, 1'b0);
        en = 1'b0;
        run("frz", 5, 4'b0011, 1'b1, 1'b0);
        mode = 2'b00;
        run("frz_mode", 5, 4'b0011, 1'b1, 1'b0);
        mode = 2'b01;
        en   = 1'b1;
        step("frz_cnt3", 4'b0011, 1'b1, 1'b0);
        step("frz_db", 4'b0000, 1'b1, 1'b0);
        step("frz_e", 4'b0000, 1'b0, 1'b1);
        step("frz_hold", 4'b0000, 1'b0, 1'b0);

        // Reset at cnt=3 discards the partial count.
        din = 4'b0100;
        run("rmc_cnt", 5, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step("rmc_rst", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        run("rmc_wait", 5, 4'h0, 1'b0, 1'b0);
        step("rmc_db", 4'b0100, 1'b0, 1'b0);
        step("rmc_e", 4'b0100, 1'b1, 1'b1);
        step("rmc_hold", 4'b0100, 1'b1, 1'b0);

        // 0000 -> 0101 with a simultaneous mode change, then back to 0000.
        din = 4'b0101;
        rst = 1'b1;
        step("eo_rst", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        run("eo_wait", 5, 4'h0, 1'b0, 1'b0);
        step("eo_rise", 4'b0101, 1'b0, 1'b0);
        mode = 2'b10;
        step("eo_simul", 4'b0101, 1'b0, 1'b0);
        mode = 2'b01;
        step("eo_or", 4'b0101, 1'b1, 1'b1);
        din = 4'b0000;
        run("eo_fwait", 5, 4'b0101, 1'b1, 1'b0);
        step("eo_fall", 4'b0000, 1'b1, 1'b0);
        step("eo_fall_e", 4'b0000, 1'b0, 1'b1);
        step("eo_end", 4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
